// File: rtl/seg7_scan_display_if.sv
// seg7_scan_display_if
//   Groups the snapshot feed (data_in/load/hold) and the display drive
//   (an/seg/dp) of the scanned 7-segment display.
//   master : the producer side (drives data_in/load/hold, sees the display)
//   slave  : the display controller (takes data_in/load/hold, drives an/seg/dp)
interface seg7_scan_display_if;
   logic [15:0] data_in;
   logic        load;
   logic        hold;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;

   modport master (output data_in, load, hold, input an, seg, dp);
   modport slave  (input data_in, load, hold, output an, seg, dp);
endinterface

// File: rtl/seg7_scan_display.sv
// seg7_scan_display
//   Snapshots a 16-bit value and shows it as 4 hex digits on a
//   time-multiplexed 7-segment display, with optional leading-zero blanking
//   and a decimal-point flash on digit 0 after the shown value changes.
// Ports:
//   clk      system clock
//   rst      synchronous, active-high reset
//   bus      seg7_scan_display_if.slave:
//              data_in[15:0] value to display
//              load          capture data_in this cycle
//              hold          freeze snapshot (overrides load)
//              an[3:0]       digit selects, an[i] = digit i
//              seg[6:0]      segments {g,f,e,d,c,b,a}
//              dp            decimal point
//   an/seg/dp are registered and lag the scan state by one cycle.
module seg7_scan_display #(
   parameter int SCAN_DIV       = 50000,
   parameter int FLASH_CYCLES   = 5000000,
   parameter int BLANK_LZ       = 1,
   parameter int SEG_ACTIVE_LOW = 1,
   parameter int AN_ACTIVE_LOW  = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   seg7_scan_display_if.slave   bus
);

   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int FL_W   = $clog2(FLASH_CYCLES + 1);

   localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
   localparam logic [FL_W-1:0]   FL_INIT   = FL_W'(FLASH_CYCLES);

   localparam logic [3:0] AN_OFF  = (AN_ACTIVE_LOW  != 0) ? 4'hF  : 4'h0;
   localparam logic [6:0] SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
   localparam logic       DP_OFF  = (SEG_ACTIVE_LOW != 0);

   logic [15:0]       snapshot;
   logic [SCAN_W-1:0] scan_cnt;
   logic [1:0]        idx;
   logic [FL_W-1:0]   flash_tmr;

   logic              capture;
   logic [3:0]        nib;
   logic              blank;
   logic [6:0]        seg_on;
   logic [3:0]        an_on;
   logic              dp_on;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;
         4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;
         4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;
         4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;
         4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;
         4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;
         4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;
         4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;
         default: hex7 = 7'h71;
      endcase
   endfunction

   assign capture = bus.load & ~bus.hold;

   // Active-high view of the next display word, from the current scan state.
   always_comb begin
      nib   = 4'h0;
      blank = 1'b0;
      case (idx)
         2'd0: nib = snapshot[3:0];
         2'd1: begin
            nib   = snapshot[7:4];
            blank = (BLANK_LZ != 0) && (snapshot[15:4] == 12'h000);
         end
         2'd2: begin
            nib   = snapshot[11:8];
            blank = (BLANK_LZ != 0) && (snapshot[15:8] == 8'h00);
         end
         default: begin
            nib   = snapshot[15:12];
            blank = (BLANK_LZ != 0) && (snapshot[15:12] == 4'h0);
         end
      endcase
      seg_on = blank ? 7'h00 : hex7(nib);
      an_on  = 4'b0001 << idx;
      dp_on  = (idx == 2'd0) && (flash_tmr != '0);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         snapshot  <= 16'h0000;
         scan_cnt  <= '0;
         idx       <= 2'd0;
         flash_tmr <= '0;
         bus.an    <= AN_OFF;
         bus.seg   <= SEG_OFF;
         bus.dp    <= DP_OFF;
      end else begin
         if (capture)
            snapshot <= bus.data_in;

         // A capture of a different value (re)starts the flash.
         if (capture && (bus.data_in != snapshot))
            flash_tmr <= FL_INIT;
         else if (flash_tmr != '0)
            flash_tmr <= flash_tmr - 1'b1;

         if (scan_cnt == SCAN_LAST) begin
            scan_cnt <= '0;
            idx      <= idx + 2'd1;
         end else begin
            scan_cnt <= scan_cnt + 1'b1;
         end

         bus.an  <= (AN_ACTIVE_LOW  != 0) ? ~an_on  : an_on;
         bus.seg <= (SEG_ACTIVE_LOW != 0) ? ~seg_on : seg_on;
         bus.dp  <= (SEG_ACTIVE_LOW != 0) ? ~dp_on  : dp_on;
      end
   end

endmodule

// File: tb/tb_seg7_scan_display.sv
module tb_seg7_scan_display;

   localparam int SD = 4;
   localparam int FC = 10;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] data_in = 16'h0000;
   logic        load = 1'b0;
   logic        hold = 1'b0;

   seg7_scan_display_if bus();

   assign bus.data_in = data_in;
   assign bus.load    = load;
   assign bus.hold    = hold;

   seg7_scan_display #(
      .SCAN_DIV(SD), .FLASH_CYCLES(FC), .BLANK_LZ(1),
      .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: e = edges since reset released, m_snap = snapshot,
   // last_chg = edge number of the most recent value-changing capture.
   int          e;
   logic [15:0] m_snap;
   int          last_chg;
   int          cur_d;
   logic [3:0]  exp_an;
   logic [6:0]  exp_seg;
   logic        exp_dp;

   logic [6:0] hex_tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // One clock edge: advance the model from the inputs applied at that edge,
   // then compare the registered outputs #1 later.
   task automatic step();
      logic [15:0] sh;
      @(posedge clk);
      #1;
      if (rst) begin
         e = 0; m_snap = 16'h0000; last_chg = -1000; cur_d = -1;
         exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
      end else begin
         e++;
         cur_d   = ((e - 1) / SD) % 4;
         sh      = m_snap >> (4 * cur_d);
         exp_an  = ~(4'b0001 << cur_d);
         if (cur_d > 0 && sh == 16'h0000) exp_seg = 7'h7F;
         else                             exp_seg = ~hex_tbl[sh[3:0]];
         exp_dp  = !(cur_d == 0 && (e - last_chg) >= 1 && (e - last_chg) <= FC);
         if (load && !hold) begin
            if (data_in != m_snap) last_chg = e;
            m_snap = data_in;
         end
      end
      check("an",  {12'h0, bus.an},  {12'h0, exp_an});
      check("seg", {9'h0, bus.seg},  {9'h0, exp_seg});
      check("dp",  {15'h0, bus.dp},  {15'h0, exp_dp});
   endtask

   // Full scan with literal per-digit segment expectations (index = digit).
   task automatic scan_lit(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                           input logic [6:0] s2, input logic [6:0] s3);
      logic [6:0] lit [4];
      lit[0] = s0; lit[1] = s1; lit[2] = s2; lit[3] = s3;
      for (int k = 0; k < 4 * SD; k++) begin
         step();
         check(tag, {9'h0, bus.seg}, {9'h0, lit[cur_d]});
      end
   endtask

   initial begin
      // 1. reset then free-running blank scan of value 0
      rst = 1'b1;
      for (int k = 0; k < 3; k++) step();
      rst = 1'b0;
      step();
      check("first_an",  {12'h0, bus.an},  16'h000E);
      check("first_seg", {9'h0, bus.seg},  16'h0040);
      for (int k = 0; k < 19; k++) step();

      // 2. load 1A3F, watch flash and one full scan
      data_in = 16'h1A3F; load = 1'b1;
      step();
      load = 1'b0;
      scan_lit("lit_1a3f", 7'h0E, 7'h30, 7'h08, 7'h79);

      // 3. same value reloaded: no flash
      load = 1'b1;
      step();
      load = 1'b0;
      for (int k = 0; k < 4 * SD; k++) begin
         step();
         check("noflash_dp", {15'h0, bus.dp}, 16'h0001);
      end

      // 4. hold overrides load
      hold = 1'b1; load = 1'b1; data_in = 16'h0042;
      scan_lit("lit_hold", 7'h0E, 7'h30, 7'h08, 7'h79);

      // 5. release hold, load 0042
      hold = 1'b0;
      step();
      load = 1'b0;
      scan_lit("lit_0042", 7'h24, 7'h19, 7'h7F, 7'h7F);

      // 6. reset mid-flash with counter=2, index=2
      for (int k = 0; k < 16 && (e % 16) != 5; k++) step();
      data_in = 16'h5A5A; load = 1'b1;
      step();
      load = 1'b0;
      for (int k = 0; k < 16 && (e % 16) != 10; k++) step();
      check("pos_before_rst", e % 16, 16'd10);
      rst = 1'b1;
      step();
      check("rst_an", {12'h0, bus.an}, 16'h000F);
      rst = 1'b0;
      for (int k = 0; k < 24; k++) step();

      // Randomised phase against the model
      for (int k = 0; k < 600; k++) begin
         case ($urandom_range(0, 3))
            0: data_in = 16'h0000;
            1: data_in = 16'h0001 << $urandom_range(0, 15);
            2: data_in = m_snap;
            default: data_in = 16'($urandom);
         endcase
         load = ($urandom_range(0, 3) == 0);
         hold = ($urandom_range(0, 4) == 0);
         rst  = ($urandom_range(0, 99) == 0);
         step();
      end
      rst = 1'b0; load = 1'b0; hold = 1'b0;
      for (int k = 0; k < 20; k++) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
